axil_adder_master: RTL and testbench
====================================

AXIL_ADDER_MASTER -- requirements
Module: axil_adder_master

Interface
REQ-001 SHALL have parameter C_BASE_ADDR, default 32'h0000_0000, the adder slave's register base address.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, fixed at 32; any other value is a synthesis error.
REQ-003 SHALL have the ports below, one per line: name  direction  width  meaning.
REQ-004 ACLK  in  1  single clock; all logic rising-edge.
REQ-005 ARESETN  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  in  1  operand pair valid.
REQ-007 cmd_ready  out  1  block accepts a command.
REQ-008 cmd_data  in  64  [31:0] operand A, [63:32] operand B.
REQ-009 rsp_valid  out  1  result valid.
REQ-010 rsp_ready  in  1  consumer accepts result.
REQ-011 rsp_sum  out  32  sum read back from slave.
REQ-012 rsp_err  out  1  a non-OKAY AXI response occurred.
REQ-013 m_axi_awaddr  out  32  write address.
REQ-014 m_axi_awvalid  out  1  write address valid.
REQ-015 m_axi_awready  in  1  write address ready.
REQ-016 m_axi_wdata  out  32  write data.
REQ-017 m_axi_wstrb  out  4  write strobes, always 4'hF.
REQ-018 m_axi_wvalid  out  1  write data valid.
REQ-019 m_axi_wready  in  1  write data ready.
REQ-020 m_axi_bresp  in  2  write response.
REQ-021 m_axi_bvalid  in  1  write response valid.
REQ-022 m_axi_bready  out  1  write response ready.
REQ-023 m_axi_araddr  out  32  read address.
REQ-024 m_axi_arvalid  out  1  read address valid.
REQ-025 m_axi_arready  in  1  read address ready.
REQ-026 m_axi_rdata  in  32  read data.
REQ-027 m_axi_rresp  in  2  read response.
REQ-028 m_axi_rvalid  in  1  read data valid.
REQ-029 m_axi_rready  out  1  read data ready.

Function
REQ-030 FSM states: IDLE, WR_A, WR_B, RD, RESP; all outputs driven from registers, with no combinational input-to-output path.
REQ-031 IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch A and B, go to WR_A; cmd_ready=0 in every other state.
REQ-032 WR_A/WR_B: on entry, assert awvalid and wvalid together.
- Address: C_BASE_ADDR+0x0 for A, +0x4 for B.
- Each valid holds until its own ready handshake, then drops independently; AW-before-W and W-before-AW acceptance are both legal.
REQ-033 bready=1 only after both AW and W have been accepted in the current phase; on bvalid&bready, leave the phase.
REQ-034 RD: arvalid=1 with araddr=C_BASE_ADDR+0x8 until arready. rready=1 only after AR is accepted. On rvalid&rready, capture rdata into rsp_sum and go to RESP.
REQ-035 Error handling: bresp!=2'b00 or rresp!=2'b00 sets rsp_err=1, sets rsp_sum=0, and goes directly to RESP; no further AXI transactions are issued for that command.
REQ-036 RESP: rsp_valid=1; rsp_sum and rsp_err hold stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE, so cmd_ready rises the next cycle.
REQ-037 Latency: exactly 7 cycles from the cmd handshake to rsp_valid, against a slave that readies in the first valid cycle and responds the next cycle; longer by exactly the slave wait cycles otherwise.
REQ-038 Sum arithmetic is performed by the slave; the block passes rdata unmodified, including wrap (0xFFFFFFFF+1 gives 0).
REQ-039 Only one command is outstanding at a time; cmd_valid asserted in a non-IDLE state is ignored until IDLE.

Reset
REQ-040 ARESETN low SHALL asynchronously force:
- state IDLE, cmd_ready=1, all AXI valid/ready outputs 0;
- rsp_valid=0, rsp_sum=0, rsp_err=0, awaddr/araddr/wdata=0.
REQ-041 Reset mid-operation SHALL abandon the command with no response; the first command after reset release runs the full sequence.

Verification
REQ-042 A=3, B=5, zero-wait slave returning 8 -> AW 0x0/W 3, AW 0x4/W 5, AR 0x8; rsp_sum=8, rsp_err=0, rsp_valid at cycle 7.
REQ-043 W accepted 3 cycles before AW, awready delayed 5 cycles -> exactly one AW and one W per phase; bready low until both are accepted.
REQ-044 bresp=SLVERR on the A write -> no B write and no AR; rsp_err=1, rsp_sum=0.
REQ-045 rsp_ready low for 10 cycles -> rsp_valid, rsp_sum and rsp_err stable; cmd_ready=0; a pending cmd_valid is not accepted until after the rsp handshake.
REQ-046 ARESETN pulsed low in WR_B with awvalid=1 -> awvalid/wvalid drop immediately; after release cmd_ready=1; next command A=0xFFFFFFFF, B=1 -> rsp_sum=0, rsp_err=0.

Source files
------------

// File: rtl/axil_adder_master.sv
// AXI4-Lite master that writes operands A and B to an adder slave, reads back the sum,
// and returns it on a valid/ready response port. One command in flight at a time.
module axil_adder_master #(
  parameter logic [31:0] C_BASE_ADDR        = 32'h0000_0000,
  parameter int          C_M_AXI_DATA_WIDTH = 32
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_sum,
  output logic        rsp_err,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  if (C_M_AXI_DATA_WIDTH != 32) begin : g_width_check
    $error("axil_adder_master: C_M_AXI_DATA_WIDTH must be 32");
  end

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD, RESP} state_e;

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic [31:0] b_q, b_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] araddr_q, araddr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_sum_q, rsp_sum_d;
  logic        rsp_err_q, rsp_err_d;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    b_d         = b_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    araddr_d    = araddr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = WR_A;
          cmd_ready_d = 1'b0;
          b_d         = cmd_data[63:32];
          awaddr_d    = C_BASE_ADDR;
          wdata_d     = cmd_data[31:0];
          awvalid_d   = 1'b1;
          wvalid_d    = 1'b1;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
        end
      end
      WR_A, WR_B: begin
        // AW and W complete independently; B is only accepted once both are in.
        if (awvalid_q && m_axi_awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && m_axi_wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        bready_d = aw_done_d && w_done_d;
        if (bready_q && m_axi_bvalid) begin
          bready_d = 1'b0;
          if (m_axi_bresp != RESP_OKAY) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_sum_d   = '0;
          end else if (state_q == WR_A) begin
            state_d   = WR_B;
            awaddr_d  = C_BASE_ADDR + 32'h4;
            wdata_d   = b_q;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD;
            araddr_d  = C_BASE_ADDR + 32'h8;
            arvalid_d = 1'b1;
          end
        end
      end
      RD: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
        if (rready_q && m_axi_rvalid) begin
          rready_d    = 1'b0;
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (m_axi_rresp != RESP_OKAY);
          rsp_sum_d   = (m_axi_rresp != RESP_OKAY) ? 32'h0 : m_axi_rdata;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      b_q         <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      araddr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      b_q         <= b_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      araddr_q    <= araddr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_sum       = rsp_sum_q;
  assign rsp_err       = rsp_err_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_adder_master.sv
// Bench for axil_adder_master: behavioural adder slave with programmable wait states and
// error injection, a response scoreboard, a vector table and hand-written corner sequences.
module tb_axil_adder_master;
  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        cmd_valid, cmd_ready;
  logic [63:0] cmd_data;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_sum;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  always #5 ACLK = ~ACLK;

  axil_adder_master dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] sum;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] a, b, sum;
    logic        err;
    int          aw_dly, w_dly;
    logic        err_a, err_b, rerr;
    int          lat, n_aw, n_ar;
  } vec_t;

  // slave configuration and observation
  int          aw_dly = 0, w_dly = 0;
  logic        err_a = 0, err_b = 0, rerr = 0;
  logic [31:0] aw_log[$], w_log[$], ar_log[$];
  int          bready_early = 0;

  initial begin : slave
    logic [31:0] regs [2];
    logic        got_aw, got_w, p_aw, p_w, p_b, p_ar, p_r;
    logic [31:0] p_awaddr, p_wdata, p_araddr, cur_addr, cur_data;
    int          aw_seen, w_seen;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    regs[0] = 0; regs[1] = 0;
    got_aw = 0; got_w = 0; p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0; cur_addr = 0; cur_data = 0;
    aw_seen = 0; w_seen = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0;
        m_axi_rvalid = 0; got_aw = 0; got_w = 0; p_aw = 0; p_w = 0; p_b = 0;
        p_ar = 0; p_r = 0; aw_seen = 0; w_seen = 0;
        continue;
      end
      // handshakes that completed on the preceding rising edge
      if (p_aw) begin aw_log.push_back(p_awaddr); cur_addr = p_awaddr; got_aw = 1; aw_seen = 0; end
      if (p_w)  begin w_log.push_back(p_wdata); cur_data = p_wdata; got_w = 1; w_seen = 0; end
      if (p_b)  begin m_axi_bvalid = 0; got_aw = 0; got_w = 0; end
      if (p_r)  m_axi_rvalid = 0;
      if (p_ar) begin
        ar_log.push_back(p_araddr);
        m_axi_rvalid = 1;
        m_axi_rdata  = regs[0] + regs[1];
        m_axi_rresp  = rerr ? 2'b10 : 2'b00;
      end
      if (got_aw && got_w && !m_axi_bvalid) begin
        regs[cur_addr[2]] = cur_data;
        m_axi_bvalid = 1;
        m_axi_bresp  = ((err_a && cur_addr == 32'h0) || (err_b && cur_addr == 32'h4)) ? 2'b10 : 2'b00;
      end
      if (m_axi_bready && !(got_aw && got_w)) bready_early++;
      m_axi_awready = m_axi_awvalid && (aw_seen >= aw_dly);
      if (m_axi_awvalid) aw_seen++;
      m_axi_wready = m_axi_wvalid && (w_seen >= w_dly);
      if (m_axi_wvalid) w_seen++;
      m_axi_arready = m_axi_arvalid;
      p_aw = m_axi_awvalid && m_axi_awready; p_awaddr = m_axi_awaddr;
      p_w  = m_axi_wvalid && m_axi_wready;   p_wdata  = m_axi_wdata;
      p_b  = m_axi_bvalid && m_axi_bready;
      p_ar = m_axi_arvalid && m_axi_arready; p_araddr = m_axi_araddr;
      p_r  = m_axi_rvalid && m_axi_rready;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge ACLK);
      if (ARESETN && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected: got sum 0x%0h err %0d, want no response", rsp_sum, rsp_err);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_sum", {32'h0, rsp_sum}, {32'h0, e.sum});
          chk("rsp_err", {63'h0, rsp_err}, {63'h0, e.err});
        end
      end
    end
  end

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] es, input logic ee, input bit push);
    int n = 0;
    @(posedge ACLK); #1;
    while (!cmd_ready && n < 100) begin @(posedge ACLK); #1; n++; end
    chk("cmd_ready_before_cmd", {63'h0, cmd_ready}, 64'h1);
    cmd_data  = {b, a};
    cmd_valid = 1;
    if (push) sb.push_back('{es, ee});
    @(posedge ACLK); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin @(negedge ACLK); lat++; end while (!rsp_valid && lat < 400);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    aw_dly = v.aw_dly; w_dly = v.w_dly; err_a = v.err_a; err_b = v.err_b; rerr = v.rerr;
    aw_log.delete(); w_log.delete(); ar_log.delete(); bready_early = 0;
    send_cmd(v.a, v.b, v.sum, v.err, 1'b1);
    wait_rsp(lat);
    chk({nm, "_latency"}, lat, v.lat);
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk({nm, "_aw_count"}, aw_log.size(), v.n_aw);
    chk({nm, "_w_count"}, w_log.size(), v.n_aw);
    chk({nm, "_ar_count"}, ar_log.size(), v.n_ar);
    chk({nm, "_bready_early"}, bready_early, 0);
    chk({nm, "_idle_cmd_ready"}, {63'h0, cmd_ready}, 64'h1);
    if (aw_log.size() >= 1 && w_log.size() >= 1) begin
      chk({nm, "_awaddr_a"}, {32'h0, aw_log[0]}, 64'h0);
      chk({nm, "_wdata_a"}, {32'h0, w_log[0]}, {32'h0, v.a});
    end
    if (aw_log.size() >= 2 && w_log.size() >= 2) begin
      chk({nm, "_awaddr_b"}, {32'h0, aw_log[1]}, 64'h4);
      chk({nm, "_wdata_b"}, {32'h0, w_log[1]}, {32'h0, v.b});
    end
    if (ar_log.size() >= 1) chk({nm, "_araddr"}, {32'h0, ar_log[0]}, 64'h8);
  endtask

  initial begin : main
    vec_t vecs[9];
    vec_t v;
    int   lat, n;
    //            a             b             sum           err  awd wd ea eb re lat naw nar
    vecs[0] = '{32'd3,        32'd5,        32'd8,        1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 7,  2, 1};
    vecs[1] = '{32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 7,  2, 1};
    vecs[2] = '{32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 7,  2, 1};
    vecs[3] = '{32'd10,       32'd20,       32'd30,       1'b0, 5, 2, 1'b0, 1'b0, 1'b0, 17, 2, 1};
    vecs[4] = '{32'hA,        32'hB,        32'h15,       1'b0, 0, 4, 1'b0, 1'b0, 1'b0, 15, 2, 1};
    vecs[5] = '{32'd3,        32'd5,        32'd0,        1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 3,  1, 0};
    vecs[6] = '{32'd6,        32'd7,        32'd0,        1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 5,  2, 0};
    vecs[7] = '{32'd8,        32'd9,        32'd0,        1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 7,  2, 1};
    vecs[8] = '{32'h80000000, 32'h80000000, 32'd0,        1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 7,  2, 1};

    ARESETN = 0; cmd_valid = 0; cmd_data = 0; rsp_ready = 1;
    repeat (3) @(negedge ACLK);
    chk("rst_cmd_ready", {63'h0, cmd_ready}, 64'h1);
    chk("rst_valids", {59'h0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 64'h0);
    chk("rst_rsp", {31'h0, rsp_valid, rsp_err, rsp_sum}, 64'h0);
    chk("rst_addr", {m_axi_awaddr, m_axi_araddr}, 64'h0);
    chk("rst_wdata", {32'h0, m_axi_wdata}, 64'h0);
    chk("wstrb", {60'h0, m_axi_wstrb}, 64'hF);
    #2 ARESETN = 1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // response back-pressure with a command waiting
    aw_dly = 0; w_dly = 0; err_a = 0; err_b = 0; rerr = 0;
    rsp_ready = 0;
    send_cmd(32'd100, 32'd200, 32'd300, 1'b0, 1'b1);
    wait_rsp(lat);
    chk("hold_latency", lat, 7);
    @(posedge ACLK); #1;
    cmd_data = {32'd2, 32'd1}; cmd_valid = 1; sb.push_back('{32'd3, 1'b0});
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      chk("hold_rsp_valid", {63'h0, rsp_valid}, 64'h1);
      chk("hold_rsp_sum", {32'h0, rsp_sum}, 64'd300);
      chk("hold_rsp_err", {63'h0, rsp_err}, 64'h0);
      chk("hold_cmd_ready", {63'h0, cmd_ready}, 64'h0);
    end
    @(posedge ACLK); #1; rsp_ready = 1;
    @(negedge ACLK);
    chk("hold_cmd_ready_at_rsp_hs", {63'h0, cmd_ready}, 64'h0);
    @(negedge ACLK);
    chk("hold_cmd_ready_after_rsp", {63'h0, cmd_ready}, 64'h1);
    chk("hold_rsp_valid_drop", {63'h0, rsp_valid}, 64'h0);
    @(posedge ACLK); #1; cmd_valid = 0;
    chk("pending_cmd_taken", {63'h0, cmd_ready}, 64'h0);
    wait_rsp(lat);
    chk("pending_latency", lat, 7);
    repeat (2) @(posedge ACLK);

    // reset pulse while the B write address is outstanding
    aw_dly = 3; aw_log.delete(); w_log.delete(); ar_log.delete();
    send_cmd(32'd7, 32'd9, 32'd0, 1'b0, 1'b0);
    n = 0;
    while (!(aw_log.size() == 1 && m_axi_awvalid) && n < 100) begin @(negedge ACLK); n++; end
    chk("reach_wr_b", n < 100, 1);
    @(posedge ACLK); #2 ARESETN = 0;
    #1;
    chk("midrst_aw_w_valid", {62'h0, m_axi_awvalid, m_axi_wvalid}, 64'h0);
    chk("midrst_cmd_ready", {63'h0, cmd_ready}, 64'h1);
    @(negedge ACLK); #2 ARESETN = 1;
    @(negedge ACLK);
    chk("postrst_cmd_ready", {63'h0, cmd_ready}, 64'h1);
    chk("postrst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    v = '{32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 7, 2, 1};
    run_vec(v, "postrst");

    repeat (3) @(posedge ACLK);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
